// File: rtl/input_port_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_port_unit_pkg
// Purpose  : Shared constants and helpers for the input port unit.
// Contents : NPORTS   - number of device ports
//            SEL_W    - width of the CPU port select
//            port_lsb - low bit of port i inside the packed in_data bus
// Revision : 1.0 - initial release
// ============================================================================
package input_port_unit_pkg;

    localparam int NPORTS = 4;
    localparam int SEL_W  = 2;

    // Port i occupies in_data[port_lsb(i, WIDTH) +: WIDTH].
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_port_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : input_port_unit_if
// Purpose  : Bundles the device handshake and CPU read signals of the
//            input port unit.
// Signals  : in_data  - packed per-port device data (NPORTS*WIDTH)
//            in_stb   - per-port device strobes (asynchronous)
//            in_ack   - per-port acknowledges back to devices
//            sel      - CPU port select
//            rd_en    - CPU read/consume strobe
//            rd_data  - holding register of the selected port
//            rd_valid - occupied flag of the selected port
//            full     - per-port occupied flags
//            irq      - any port holds unread data
// Modports : master - devices/CPU side, slave - the unit itself
// Revision : 1.0 - initial release
// ============================================================================
interface input_port_unit_if #(
    parameter int WIDTH = 8
);
    import input_port_unit_pkg::*;

    logic [NPORTS*WIDTH-1:0] in_data;
    logic [NPORTS-1:0]       in_stb;
    logic [NPORTS-1:0]       in_ack;
    logic [SEL_W-1:0]        sel;
    logic                    rd_en;
    logic [WIDTH-1:0]        rd_data;
    logic                    rd_valid;
    logic [NPORTS-1:0]       full;
    logic                    irq;

    modport master (
        output in_data, in_stb, sel, rd_en,
        input  in_ack, rd_data, rd_valid, full, irq
    );

    modport slave (
        input  in_data, in_stb, sel, rd_en,
        output in_ack, rd_data, rd_valid, full, irq
    );

endinterface
`default_nettype wire

// File: rtl/input_port_unit_in_channel.sv
`default_nettype none
// ============================================================================
// Module   : input_port_unit_in_channel
// Purpose  : One device port: strobe synchroniser, 4-phase capture/ack
//            logic, holding register and occupied flag.
// Ports    : clk, reset (async, active-high)
//            stb     - device strobe (asynchronous)
//            data    - device data, stable while the handshake is open
//            clear   - CPU consumes this port's byte
//            ack     - registered acknowledge to the device
//            full    - holding register occupied
//            holding - last captured byte
// Revision : 1.0 - initial release
// ============================================================================
module input_port_unit_in_channel #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2    // must be >= 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             stb,
    input  wire logic [WIDTH-1:0] data,
    input  wire logic             clear,
    output logic                  ack,
    output logic                  full,
    output logic [WIDTH-1:0]      holding
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ack;
    logic                   r_full;
    logic [WIDTH-1:0]       r_hold;

    logic w_ssync;
    logic w_capture;
    logic w_release;

    assign w_ssync = r_sync[SYNC_STAGES-1];

    // Requiring ack low means a strobe held high is captured only once: the
    // ack stays high until the strobe drops, so no second capture can occur.
    assign w_capture = w_ssync && !r_full && !r_ack;
    assign w_release = !w_ssync && r_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_ack  <= 1'b0;
            r_full <= 1'b0;
            r_hold <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], stb};
            if (w_capture) begin
                r_hold <= data;
                r_full <= 1'b1;
                r_ack  <= 1'b1;
            end else begin
                // Capture needs full low and a consume needs full high, so the
                // two never collide on the same edge.
                if (w_release) begin
                    r_ack <= 1'b0;
                end
                if (clear && r_full) begin
                    r_full <= 1'b0;
                end
            end
        end
    end

    assign ack     = r_ack;
    assign full    = r_full;
    assign holding = r_hold;

endmodule
`default_nettype wire

// File: rtl/input_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : input_port_unit
// Purpose  : Receives bytes from NPORTS devices over strobe/ack handshakes
//            and presents them to the CPU through a select/consume port.
// Ports    : clk, reset (async, active-high)
//            bus - input_port_unit_if.slave (device handshake + CPU read)
// Revision : 1.0 - initial release
// ============================================================================
module input_port_unit #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input_port_unit_if.slave   bus
);
    import input_port_unit_pkg::*;

    logic [WIDTH-1:0]  w_hold [NPORTS];
    logic [NPORTS-1:0] w_full;
    logic [NPORTS-1:0] w_ack;

    generate
        for (genvar i = 0; i < NPORTS; i++) begin : g_port
            logic w_clear;

            // Only the port selected at the rd_en edge is consumed.
            assign w_clear = bus.rd_en && (bus.sel == SEL_W'(i));

            input_port_unit_in_channel #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_channel (
                .clk     (clk),
                .reset   (reset),
                .stb     (bus.in_stb[i]),
                .data    (bus.in_data[port_lsb(i, WIDTH) +: WIDTH]),
                .clear   (w_clear),
                .ack     (w_ack[i]),
                .full    (w_full[i]),
                .holding (w_hold[i])
            );
        end
    endgenerate

    assign bus.in_ack   = w_ack;
    assign bus.full     = w_full;
    assign bus.rd_data  = w_hold[bus.sel];
    assign bus.rd_valid = w_full[bus.sel];
    assign bus.irq      = |w_full;

endmodule
`default_nettype wire

// File: tb/tb_input_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_port_unit
// Purpose  : Self-checking bench for input_port_unit (WIDTH=8,
//            SYNC_STAGES=2): per-cycle vector table plus directed
//            sequences for reset, backpressure and held strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_port_unit;

    logic clk;
    logic reset;

    input_port_unit_if #(.WIDTH(8)) bus ();

    input_port_unit #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance n rising edges and sample 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bus.in_stb  = '0;
        bus.in_data = '0;
        bus.sel     = '0;
        bus.rd_en   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  stb;
        logic [31:0] data;
        logic [1:0]  sel;
        logic        rd_en;
        logic [3:0]  e_ack;
        logic [3:0]  e_full;
        logic [7:0]  e_rd;
        logic        e_vld;
        logic        e_irq;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Rows: inputs driven before an edge, expected outputs after it.
        // Single handshake on port 1 (0xA5), sel=1.
        tbl[0]  = '{4'b0010, 32'h0000A500, 2'd1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{4'b0010, 32'h0000A500, 2'd1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 32'h0000A500, 2'd1, 1'b0, 4'b0010, 4'b0010, 8'hA5, 1'b1, 1'b1};
        tbl[3]  = '{4'b0000, 32'h0000A500, 2'd1, 1'b0, 4'b0010, 4'b0010, 8'hA5, 1'b1, 1'b1};
        tbl[4]  = '{4'b0000, 32'h0000A500, 2'd1, 1'b0, 4'b0010, 4'b0010, 8'hA5, 1'b1, 1'b1};
        tbl[5]  = '{4'b0000, 32'h0000A500, 2'd1, 1'b0, 4'b0000, 4'b0010, 8'hA5, 1'b1, 1'b1};
        tbl[6]  = '{4'b0000, 32'h0000A500, 2'd1, 1'b1, 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0};
        tbl[7]  = '{4'b0000, 32'h0000A500, 2'd1, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0};
        // All four ports together (01..04), then consume port 2 while port 3
        // is re-armed but still full.
        tbl[8]  = '{4'b1111, 32'h04030201, 2'd2, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{4'b1111, 32'h04030201, 2'd2, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{4'b1111, 32'h04030201, 2'd2, 1'b0, 4'b1111, 4'b1111, 8'h03, 1'b1, 1'b1};
        tbl[11] = '{4'b0000, 32'h04030201, 2'd2, 1'b0, 4'b1111, 4'b1111, 8'h03, 1'b1, 1'b1};
        tbl[12] = '{4'b0000, 32'h04030201, 2'd2, 1'b0, 4'b1111, 4'b1111, 8'h03, 1'b1, 1'b1};
        tbl[13] = '{4'b0000, 32'h04030201, 2'd2, 1'b0, 4'b0000, 4'b1111, 8'h03, 1'b1, 1'b1};
        tbl[14] = '{4'b1000, 32'h44030201, 2'd2, 1'b1, 4'b0000, 4'b1011, 8'h03, 1'b0, 1'b1};
        tbl[15] = '{4'b1000, 32'h44030201, 2'd2, 1'b0, 4'b0000, 4'b1011, 8'h03, 1'b0, 1'b1};
        tbl[16] = '{4'b1000, 32'h44030201, 2'd2, 1'b0, 4'b0000, 4'b1011, 8'h03, 1'b0, 1'b1};
        tbl[17] = '{4'b1000, 32'h44030201, 2'd3, 1'b0, 4'b0000, 4'b1011, 8'h04, 1'b1, 1'b1};

        reset       = 1'b1;
        bus.in_stb  = '0;
        bus.in_data = '0;
        bus.sel     = '0;
        bus.rd_en   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ---------------- empty read after reset ----------------
        do_reset();
        bus.sel   = 2'd0;
        bus.rd_en = 1'b1;
        #1;
        chk("empty rd_valid pre", 32'(bus.rd_valid), 32'd0);
        chk("empty rd_data pre",  32'(bus.rd_data),  32'h00);
        tick(1);
        bus.rd_en = 1'b0;
        chk("empty full",     32'(bus.full),     32'h0);
        chk("empty ack",      32'(bus.in_ack),   32'h0);
        chk("empty rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("empty rd_data",  32'(bus.rd_data),  32'h00);
        chk("empty irq",      32'(bus.irq),      32'd0);

        // ---------------- vector table ----------------
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus.in_stb  = tbl[i].stb;
            bus.in_data = tbl[i].data;
            bus.sel     = tbl[i].sel;
            bus.rd_en   = tbl[i].rd_en;
            tick(1);
            chk($sformatf("row%0d ack", i),     32'(bus.in_ack),   32'(tbl[i].e_ack));
            chk($sformatf("row%0d full", i),    32'(bus.full),     32'(tbl[i].e_full));
            chk($sformatf("row%0d rd_data", i), 32'(bus.rd_data),  32'(tbl[i].e_rd));
            chk($sformatf("row%0d rd_valid", i),32'(bus.rd_valid), 32'(tbl[i].e_vld));
            chk($sformatf("row%0d irq", i),     32'(bus.irq),      32'(tbl[i].e_irq));
        end

        // ---------------- backpressure on port 0 ----------------
        do_reset();
        bus.sel     = 2'd0;
        bus.in_data = 32'h00000011;
        bus.in_stb  = 4'b0001;
        tick(3);
        chk("bp first full", 32'(bus.full),   32'h1);
        chk("bp first ack",  32'(bus.in_ack), 32'h1);
        bus.in_stb = 4'b0000;
        tick(3);
        chk("bp ack released", 32'(bus.in_ack), 32'h0);
        bus.in_data = 32'h00000022;
        bus.in_stb  = 4'b0001;
        tick(4);
        chk("bp blocked ack",  32'(bus.in_ack),  32'h0);
        chk("bp blocked full", 32'(bus.full),    32'h1);
        chk("bp held data",    32'(bus.rd_data), 32'h11);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("bp read full", 32'(bus.full),   32'h0);
        chk("bp read ack",  32'(bus.in_ack), 32'h0);
        tick(1);
        chk("bp recap full", 32'(bus.full),    32'h1);
        chk("bp recap ack",  32'(bus.in_ack),  32'h1);
        chk("bp recap data", 32'(bus.rd_data), 32'h22);

        // ---------------- held strobe on port 3 ----------------
        do_reset();
        begin
            int  captures;
            logic prev;
            captures    = 0;
            prev        = 1'b0;
            bus.sel     = 2'd3;
            bus.in_data = 32'h3C000000;
            bus.in_stb  = 4'b1000;
            for (int c = 0; c < 20; c++) begin
                bus.rd_en = (c == 10);
                tick(1);
                if (bus.full[3] && !prev) captures++;
                prev = bus.full[3];
            end
            bus.rd_en = 1'b0;
            chk("held captures", 32'(captures),       32'd1);
            chk("held full3",    32'(bus.full[3]),    32'd0);
            chk("held ack3",     32'(bus.in_ack[3]),  32'd1);
        end
        bus.in_stb = 4'b0000;
        tick(3);
        chk("held ack drop", 32'(bus.in_ack[3]), 32'd0);
        bus.in_data = 32'h3D000000;
        bus.in_stb  = 4'b1000;
        tick(3);
        chk("held retoggle full", 32'(bus.full[3]), 32'd1);
        chk("held retoggle data", 32'(bus.rd_data), 32'h3D);

        // ---------------- asynchronous reset mid-run ----------------
        bus.sel     = 2'd2;
        bus.in_data = 32'h3D5A0000;
        bus.in_stb  = 4'b1100;
        tick(3);
        chk("mid pre full2", 32'(bus.full[2]),   32'd1);
        chk("mid pre ack2",  32'(bus.in_ack[2]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid reset full",    32'(bus.full),    32'h0);
        chk("mid reset ack",     32'(bus.in_ack),  32'h0);
        chk("mid reset rd_data", 32'(bus.rd_data), 32'h00);
        chk("mid reset irq",     32'(bus.irq),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        chk("mid resync early", 32'(bus.full[2]), 32'd0);
        tick(1);
        chk("mid recapture full", 32'(bus.full[2]), 32'd1);
        chk("mid recapture data", 32'(bus.rd_data), 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
